// File: rtl/vertex_transform_sequencer.sv
// vertex_transform_sequencer: front-end sequencer for the 4x4 x 4x1 float
// transform engine. It keeps the transform matrix, buffers one vertex, streams
// the matrix and then the vertex into the engine load port, and drains the
// four result words to a downstream valid/ready stream.
// Build option VTX_SEQ_FORCE_W_EN: collect x, y, z only and force w = 1.0.
module vertex_transform_sequencer #(
  parameter int unsigned MAT_WORDS = 16,
  parameter int unsigned VEC_WORDS = 4
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        mat_wr,
  input  logic [3:0]  mat_addr,
  input  logic [31:0] mat_data,
  output logic        mat_busy,
  input  logic        vtx_valid,
  input  logic [31:0] vtx_data,
  output logic        vtx_ready,
  input  logic        eng_ready,
  output logic        eng_data_valid,
  output logic [31:0] eng_data,
  input  logic        eng_data_done,
  input  logic        eng_calc_done,
  input  logic [31:0] eng_result,
  output logic        eng_read_done,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready
);

  localparam int unsigned LOAD_WORDS = MAT_WORDS + VEC_WORDS;
  localparam int unsigned IDX_W      = $clog2(LOAD_WORDS);
  localparam int unsigned VCNT_W     = $clog2(VEC_WORDS + 1);
  localparam int unsigned VIDX_W     = $clog2(VEC_WORDS);
  localparam int unsigned MIDX_W     = $clog2(MAT_WORDS);
  localparam logic [31:0] ONE_F      = 32'h3F80_0000;

`ifdef VTX_SEQ_FORCE_W_EN
  localparam int unsigned COLLECT_WORDS = VEC_WORDS - 1;
`else
  localparam int unsigned COLLECT_WORDS = VEC_WORDS;
`endif

  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(COLLECT_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LOAD_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_VEC0  = IDX_W'(MAT_WORDS);
  localparam logic [VIDX_W-1:0] RCNT_LAST = VIDX_W'(VEC_WORDS - 1);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_WAIT_ENG,
    ST_SEND,
    ST_WAIT_DONE,
    ST_WAIT_CALC,
    ST_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VIDX_W-1:0]   rcnt_q, rcnt_d;
  logic [31:0]         vbuf_q [VEC_WORDS];
  logic [31:0]         mat_q  [MAT_WORDS];

  logic                vtx_fire;
  logic                vtx_last;
  logic                out_fire;
  logic [VIDX_W-1:0]   vsel;

  assign vtx_fire = (state_q == ST_COLLECT) && vtx_valid;
  assign vtx_last = vtx_fire && (vcnt_q == VCNT_LAST);
  assign out_fire = (state_q == ST_DRAIN) && eng_calc_done && out_ready;
  assign vsel     = VIDX_W'(idx_q - IDX_VEC0);

  // Control state and counters.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= ST_COLLECT;
      vcnt_q  <= '0;
      idx_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vcnt_q  <= vcnt_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic: each wait state only looks at its own engine flag.
  always_comb begin
    state_d = state_q;
    vcnt_d  = vcnt_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_COLLECT: begin
        if (vtx_fire) begin
          vcnt_d = vcnt_q + 1'b1;
          if (vcnt_q == VCNT_LAST) state_d = ST_WAIT_ENG;
        end
      end
      ST_WAIT_ENG: begin
        if (eng_ready) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_WAIT_DONE;
          idx_d   = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (eng_data_done) state_d = ST_WAIT_CALC;
      end
      ST_WAIT_CALC: begin
        if (eng_calc_done) begin
          state_d = ST_DRAIN;
          rcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == RCNT_LAST) begin
            state_d = ST_COLLECT;
            vcnt_d  = '0;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Vertex buffer; with forced w the last slot is loaded with 1.0 on the
  // same edge that accepts z.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int unsigned i = 0; i < VEC_WORDS; i++) vbuf_q[i] <= '0;
    end else begin
      if (vtx_fire) vbuf_q[vcnt_q[VIDX_W-1:0]] <= vtx_data;
`ifdef VTX_SEQ_FORCE_W_EN
      if (vtx_last) vbuf_q[VEC_WORDS-1] <= ONE_F;
`else
      if (vtx_last) vbuf_q[VEC_WORDS-1] <= vtx_data;
`endif
    end
  end

  // Matrix store: resets to identity, writable only while collecting.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int unsigned i = 0; i < MAT_WORDS; i++)
        mat_q[i] <= ((i / 4) == (i % 4)) ? ONE_F : '0;
    end else if (mat_wr && (state_q == ST_COLLECT)) begin
      mat_q[mat_addr] <= mat_data;
    end
  end

  // Output decode: engine load mux and gated result pass-through.
  always_comb begin
    vtx_ready      = (state_q == ST_COLLECT);
    mat_busy       = (state_q != ST_COLLECT);
    eng_data_valid = 1'b0;
    eng_data       = '0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_last       = 1'b0;
    eng_read_done  = 1'b0;
    if (state_q == ST_SEND) begin
      eng_data_valid = 1'b1;
      if (idx_q < IDX_VEC0) eng_data = mat_q[idx_q[MIDX_W-1:0]];
      else                  eng_data = vbuf_q[vsel];
    end
    if (state_q == ST_DRAIN) begin
      out_valid     = eng_calc_done;
      out_data      = eng_result;
      out_last      = (rcnt_q == RCNT_LAST);
      eng_read_done = out_fire;
    end
  end

endmodule

// File: tb/tb_vertex_transform_sequencer.sv
// Bench for vertex_transform_sequencer: randomized vertex/matrix traffic with
// a behavioural engine stub and a float matrix-vector reference model.
module tb_vertex_transform_sequencer;

`ifdef VTX_SEQ_FORCE_W_EN
  localparam int VW = 3;
`else
  localparam int VW = 4;
`endif
  localparam logic [31:0] ONE_F = 32'h3F80_0000;

  logic        iClk = 1'b0;
  logic        iRstn;
  logic        mat_wr;
  logic [3:0]  mat_addr;
  logic [31:0] mat_data;
  logic        mat_busy;
  logic        vtx_valid;
  logic [31:0] vtx_data;
  logic        vtx_ready;
  logic        eng_ready;
  logic        eng_data_valid;
  logic [31:0] eng_data;
  logic        eng_data_done;
  logic        eng_calc_done;
  logic [31:0] eng_result;
  logic        eng_read_done;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  always #5 iClk = ~iClk;

  vertex_transform_sequencer #(.MAT_WORDS(16), .VEC_WORDS(4)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .mat_wr(mat_wr), .mat_addr(mat_addr), .mat_data(mat_data), .mat_busy(mat_busy),
    .vtx_valid(vtx_valid), .vtx_data(vtx_data), .vtx_ready(vtx_ready),
    .eng_ready(eng_ready), .eng_data_valid(eng_data_valid), .eng_data(eng_data),
    .eng_data_done(eng_data_done), .eng_calc_done(eng_calc_done),
    .eng_result(eng_result), .eng_read_done(eng_read_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] ref_mat [16];
  logic [31:0] ref_vec [4];
  logic [31:0] first_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real a;
    int  e;
    logic [22:0] m;
    logic [7:0]  ex;
    if (x == 0.0) return '0;
    a = (x < 0.0) ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m  = 23'($rtoi((a - 1.0) * 8388608.0));
    ex = 8'(e);
    return {(x < 0.0), ex, m};
  endfunction

  // Small dyadic values keep every dot product exactly representable.
  function automatic logic [31:0] rnd_f();
    real v;
    v = real'(int'($urandom_range(0, 8)) - 4);
    if ($urandom_range(0, 3) == 0) v = v / 2.0;
    return r2f(v);
  endfunction

  function automatic logic [31:0] mat_vec_row(input logic [31:0] m [16],
                                              input logic [31:0] v [4], input int row);
    real acc;
    acc = 0.0;
    for (int j = 0; j < 4; j++) acc = acc + f2r(m[row*4 + j]) * f2r(v[j]);
    return r2f(acc);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mat[i] = ((i / 4) == (i % 4)) ? ONE_F : 32'h0;
  endtask

  task automatic set_idle();
    mat_wr = 0; mat_addr = '0; mat_data = '0;
    vtx_valid = 0; vtx_data = '0;
    eng_ready = 0; eng_data_done = 0; eng_calc_done = 0; eng_result = '0;
    out_ready = 0;
  endtask

  task automatic write_mat(input logic [3:0] a, input logic [31:0] d);
    @(negedge iClk);
    set_idle();
    mat_wr = 1; mat_addr = a; mat_data = d;
    #1;
    check_eq("wr_mat_busy", 32'(mat_busy), 32'd0);
    ref_mat[a] = d;
    @(negedge iClk);
    mat_wr = 0;
  endtask

  // One full vertex: collect, engine load, engine wait, drain.
  task automatic run_vertex(input logic [31:0] vin [4], input bit rand_wr, input bit send_wr,
                            input bit bp_toggle, input bit glitch, input bit rst_at_10);
    logic [31:0] eng_words [$];
    logic [31:0] em [16];
    logic [31:0] ev [4];
    logic [31:0] eres [4];
    logic [31:0] rout [4];
    int got, budget, acc, ek, rd_pulses, nwait;
    logic [31:0] expw;

    got = 0; budget = 0;
    while (got < VW && budget < 100) begin
      @(negedge iClk);
      vtx_valid = ($urandom_range(0, 3) != 0);
      vtx_data  = vin[got];
      mat_wr    = rand_wr && ($urandom_range(0, 1) == 1);
      mat_addr  = 4'($urandom);
      mat_data  = rnd_f();
      eng_ready = ($urandom_range(0, 1) == 1);
      eng_calc_done = ($urandom_range(0, 1) == 1);
      eng_result = $urandom;
      out_ready = 1;
      #1;
      check_eq("col_vtx_ready", 32'(vtx_ready), 32'd1);
      check_eq("col_out_valid", 32'(out_valid), 32'd0);
      check_eq("col_out_data", out_data, 32'h0);
      check_eq("col_eng_valid", 32'(eng_data_valid), 32'd0);
      if (mat_wr) ref_mat[mat_addr] = mat_data;
      if (vtx_valid) begin ref_vec[got] = vtx_data; got++; end
      budget++;
    end
    if (got < VW) check_eq("col_timeout", 32'(got), 32'(VW));
    if (VW == 3) ref_vec[3] = ONE_F;
    for (int i = 0; i < 4; i++) rout[i] = mat_vec_row(ref_mat, ref_vec, i);

    nwait = $urandom_range(1, 3);
    for (int c = 0; c < nwait; c++) begin
      @(negedge iClk);
      set_idle();
      vtx_valid = 1; vtx_data = $urandom;
      #1;
      check_eq("we_vtx_ready", 32'(vtx_ready), 32'd0);
      check_eq("we_mat_busy", 32'(mat_busy), 32'd1);
      check_eq("we_eng_valid", 32'(eng_data_valid), 32'd0);
    end
    @(negedge iClk);
    vtx_valid = 0;
    eng_ready = 1;
    #1;
    check_eq("we_ready_seen", 32'(eng_data_valid), 32'd0);

    for (int w = 0; w < 20; w++) begin
      @(negedge iClk);
      eng_ready = 0;
      mat_wr    = send_wr;
      mat_addr  = 4'($urandom);
      mat_data  = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
      #1;
      if (rst_at_10 && w == 10) begin
        iRstn = 0;
        #1;
        check_eq("rst_eng_valid", 32'(eng_data_valid), 32'd0);
        check_eq("rst_vtx_ready", 32'(vtx_ready), 32'd1);
        check_eq("rst_mat_busy", 32'(mat_busy), 32'd0);
        ref_reset();
        @(negedge iClk);
        set_idle();
        iRstn = 1;
        return;
      end
      expw = (w < 16) ? ref_mat[w] : ref_vec[w-16];
      check_eq($sformatf("send_valid_%0d", w), 32'(eng_data_valid), 32'd1);
      check_eq($sformatf("send_word_%0d", w), eng_data, expw);
      check_eq("send_mat_busy", 32'(mat_busy), 32'd1);
      if (eng_data_valid) eng_words.push_back(eng_data);
    end

    nwait = $urandom_range(1, 4);
    for (int c = 0; c < nwait; c++) begin
      @(negedge iClk);
      mat_wr = 0;
      eng_calc_done = ($urandom_range(0, 1) == 1);
      eng_result = $urandom;
      #1;
      check_eq("wd_eng_valid", 32'(eng_data_valid), 32'd0);
      check_eq("wd_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge iClk);
    eng_calc_done = 0;
    eng_data_done = 1;
    #1;
    check_eq("wd_done_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 16; i++) em[i] = (i < eng_words.size()) ? eng_words[i] : 32'h0;
    for (int i = 0; i < 4; i++) ev[i] = (i + 16 < eng_words.size()) ? eng_words[i+16] : 32'h0;
    for (int i = 0; i < 4; i++) eres[i] = mat_vec_row(em, ev, i);

    nwait = $urandom_range(0, 3);
    for (int c = 0; c < nwait; c++) begin
      @(negedge iClk);
      eng_data_done = 0;
      eng_ready = ($urandom_range(0, 1) == 1);
      eng_result = $urandom;
      #1;
      check_eq("wc_out_valid", 32'(out_valid), 32'd0);
      check_eq("wc_eng_valid", 32'(eng_data_valid), 32'd0);
    end
    @(negedge iClk);
    eng_data_done = 0;
    eng_ready = 0;
    eng_calc_done = 1;
    eng_result = eres[0];
    out_ready = 0;
    #1;
    check_eq("wc_calc_seen", 32'(out_valid), 32'd0);

    acc = 0; ek = 0; rd_pulses = 0; budget = 0;
    while (acc < 4 && budget < 60) begin
      @(negedge iClk);
      eng_calc_done = glitch ? ($urandom_range(0, 3) != 0) : 1'b1;
      eng_result = (ek < 4) ? eres[ek] : 32'h0;
      out_ready = bp_toggle ? ((budget % 2) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      check_eq("dr_out_valid", 32'(out_valid), 32'(eng_calc_done));
      check_eq("dr_out_last", 32'(out_last), 32'(acc == 3));
      check_eq("dr_read_done", 32'(eng_read_done), 32'(eng_calc_done && out_ready));
      if (eng_calc_done) check_eq($sformatf("dr_data_%0d", acc), out_data, rout[acc]);
      if (eng_calc_done && out_ready) begin
        if (acc == 0) first_out = out_data;
        acc++;
      end
      if (eng_read_done) begin ek++; rd_pulses++; end
      budget++;
    end
    check_eq("dr_read_pulses", 32'(rd_pulses), 32'd4);

    @(negedge iClk);
    set_idle();
    eng_calc_done = 1;
    eng_result = $urandom;
    #1;
    check_eq("post_vtx_ready", 32'(vtx_ready), 32'd1);
    check_eq("post_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_out_data", out_data, 32'h0);
    eng_calc_done = 0;
  endtask

  logic [31:0] v123 [4];
  logic [31:0] vr [4];

  initial begin
    iRstn = 1;
    set_idle();
    ref_reset();
    for (int i = 0; i < 4; i++) ref_vec[i] = 32'h0;
    first_out = '0;
    #1 iRstn = 0;
    #1;
    check_eq("rst_vtx_ready", 32'(vtx_ready), 32'd1);
    check_eq("rst_mat_busy", 32'(mat_busy), 32'd0);
    check_eq("rst_eng_valid", 32'(eng_data_valid), 32'd0);
    check_eq("rst_eng_data", eng_data, 32'h0);
    check_eq("rst_read_done", 32'(eng_read_done), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(negedge iClk);
    iRstn = 1;

    v123[0] = 32'h3F80_0000; v123[1] = 32'h4000_0000;
    v123[2] = 32'h4040_0000; v123[3] = 32'h3F80_0000;

    // identity pass-through
    run_vertex(v123, 0, 0, 0, 0, 0);
    check_eq("ident_x", first_out, 32'h3F80_0000);

    // translate x by 10 -> x' = 11.0
    write_mat(4'd3, 32'h4120_0000);
    run_vertex(v123, 0, 0, 0, 0, 0);
    check_eq("translate_x", first_out, 32'h4130_0000);

    // writes during SEND are ignored; following vertex still sees old matrix
    run_vertex(v123, 0, 1, 0, 0, 0);
    run_vertex(v123, 0, 0, 0, 0, 0);
    check_eq("send_wr_ignored_x", first_out, 32'h4130_0000);

    // toggled back-pressure
    run_vertex(v123, 0, 0, 1, 0, 0);

    // reset in the middle of the load, then identity again
    run_vertex(v123, 0, 0, 0, 0, 1);
    run_vertex(v123, 0, 0, 0, 0, 0);
    check_eq("post_rst_ident_x", first_out, 32'h3F80_0000);

    // random traffic
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) vr[i] = rnd_f();
      run_vertex(vr, 1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vertex_transform_sequencer.md
# vertex_transform_sequencer

Front-end sequencer for the 4x4·4x1 float transform engine. Holds the 16-word transform matrix, buffers one incoming vertex (x, y, z, w as IEEE-754 single words), streams matrix plus vertex into the engine's load port, then drains the four result words to a downstream valid/ready stream. One vertex is in flight at a time.

## Interface
Parameters:
- MAT_WORDS, 16, matrix words sent per vertex, row-major m00..m33
- VEC_WORDS, 4, vector words per vertex (x, y, z, w)

Ports:
- iClk  in  1  clock; all logic rising-edge
- iRstn  in  1  reset; asynchronous, active-low
- mat_wr  in  1  matrix write strobe; honoured only while mat_busy=0
- mat_addr  in  4  matrix word index, row*4+col
- mat_data  in  32  matrix word
- mat_busy  out  1  high outside COLLECT; matrix writes ignored
- vtx_valid  in  1  upstream vertex word valid
- vtx_data  in  32  vertex word
- vtx_ready  out  1  sequencer accepts vertex word
- eng_ready  in  1  engine idle, may start a load
- eng_data_valid  out  1  engine load word valid
- eng_data  out  32  engine load word
- eng_data_done  in  1  engine has all 20 words
- eng_calc_done  in  1  engine result available on eng_result
- eng_result  in  32  current engine result word
- eng_read_done  out  1  one-cycle pulse: current result consumed
- out_valid  out  1  downstream result valid
- out_data  out  32  result word (x', y', z', w' in order)
- out_last  out  1  marks w' word
- out_ready  in  1  downstream accepts

## Operation
- States: COLLECT, WAIT_ENG, SEND, WAIT_DONE, WAIT_CALC, DRAIN.
- COLLECT: vtx_ready=1; each vtx_valid&&vtx_ready writes vbuf[vcnt], vcnt++; after 4th word -> WAIT_ENG. mat_wr writes mat[mat_addr]; same-cycle mat_wr and vertex word both take effect.
- WAIT_ENG: wait eng_ready=1 -> SEND, idx=0.
- SEND: eng_data_valid=1 every cycle; eng_data = mat[idx] for idx 0..15, vbuf[idx-16] for 16..19; idx++ each cycle; after idx=19 -> WAIT_DONE. Stream is unbroken; engine samples one word per cycle.
- WAIT_DONE: wait eng_data_done=1 -> WAIT_CALC.
- WAIT_CALC: wait eng_calc_done=1 -> DRAIN, rcnt=0.
- DRAIN: out_valid = eng_calc_done; out_data = eng_result (combinational pass-through); out_last = (rcnt==3). On out_valid&&out_ready: eng_read_done pulses, rcnt++; after 4th transfer -> COLLECT, vcnt=0.
- Matrix persists across vertices; not cleared by vertex traffic.
- Arithmetic: none in this block; words pass bit-exact.

## Timing
- Reset (async assert, sync deassert at next edge): state=COLLECT, vcnt=idx=rcnt=0, vbuf=0, mat=identity (diagonal 0x3F800000, others 0). Outputs: vtx_ready=1, mat_busy=0, eng_data_valid=0, eng_data=0, eng_read_done=0, out_valid=0, out_data=0 (gated to 0 outside DRAIN), out_last=0.
- Load latency: first engine word one cycle after WAIT_ENG sees eng_ready; 20 cycles of eng_data_valid exactly.
- Minimum vertex period: 4 (collect) + 1 + 20 + engine latency + 4 drain cycles.
- out_valid may drop mid-drain if eng_calc_done drops; rcnt holds, no read_done.
- Downstream back-pressure: out_ready=0 holds rcnt, no read_done.
- Reset mid-SEND or mid-DRAIN: all counters cleared, partial vertex discarded, matrix returns to identity.
- eng_ready ignored outside WAIT_ENG; eng_data_done/eng_calc_done ignored outside their wait states.

## Configuration
- VTX_SEQ_FORCE_W_EN defined: vertex collect takes 3 words (x, y, z); vbuf[3] forced to 0x3F800000 at collect completion; vtx_ready drops after 3rd word.
- Undefined: 4 words collected, w taken from stream.
- Engine load is 20 words in both cases.

## Test plan
- Reset, no matrix writes, vertex {1.0,2.0,3.0,1.0} (0x3F800000,0x40000000,0x40400000,0x3F800000) -> eng_data shows identity then vertex over 20 consecutive cycles; with engine model, out stream 0x3F800000,0x40000000,0x40400000,0x3F800000, out_last on 4th.
- Write mat[3]=0x41200000 (translate x by 10) in COLLECT, vertex (1,2,3,1) -> eng_data word 3 = 0x41200000; model result x'=0x41300000 (11.0).
- mat_wr during SEND -> ignored; mat_busy=1; next vertex load uses old matrix.
- out_ready toggled 1/0 each cycle during DRAIN -> exactly 4 eng_read_done pulses, each coincident with an accepted word, order preserved.
- Assert iRstn=0 at SEND idx=10 -> eng_data_valid=0 immediately, vtx_ready=1, mat back to identity after release.
- VTX_SEQ_FORCE_W_EN: send 3 words -> vtx_ready low after 3rd, eng_data word 19 = 0x3F800000.
